// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   state_e        - sequencer states (idle / memory access / response)
//   P_DATA/FETCH/DEBUG - requester port indices
//   MEM_BYTES_DEF  - default memory size in bytes
//   ALIGN_MASK     - required value of addr[1:0] for a word access
//   port_onehot()  - port index to one-hot ack vector
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic [1:0] P_DATA  = 2'd0;
  localparam logic [1:0] P_FETCH = 2'd1;
  localparam logic [1:0] P_DEBUG = 2'd2;

  localparam int unsigned MEM_BYTES_DEF = 256;

  localparam logic [1:0] ALIGN_MASK = 2'b00;

  function automatic logic [2:0] port_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rr_pick3: combinational three-way round-robin picker.
//   i_req   [2:0] - request vector, one bit per port
//   i_last  [1:0] - most recently granted port
//   o_grant [1:0] - winning port, searched from (last+1) mod 3 upward
//   o_valid       - at least one request is present
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic [1:0] o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = P_DATA;
    case (i_last)
      P_DATA: begin
        if (i_req[P_FETCH])      o_grant = P_FETCH;
        else if (i_req[P_DEBUG]) o_grant = P_DEBUG;
        else                     o_grant = P_DATA;
      end
      P_FETCH: begin
        if (i_req[P_DEBUG])      o_grant = P_DEBUG;
        else if (i_req[P_DATA])  o_grant = P_DATA;
        else                     o_grant = P_FETCH;
      end
      // last == 2 (and the unused encoding 3) start the search at port 0
      default: begin
        if (i_req[P_DATA])       o_grant = P_DATA;
        else if (i_req[P_FETCH]) o_grant = P_FETCH;
        else                     o_grant = P_DEBUG;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port round-robin arbiter / sequencer for a single
// unified byte-addressed word memory (combinational read, clocked write).
//   i_clk, i_rst            - clock, asynchronous active-high reset
//   i_req/i_we [2:0]        - per-port request and write enable (held until ack)
//   i_addr0..2, i_wdata0..2 - per-port byte address and write data
//   o_ack [2:0]             - one-hot, one-cycle completion pulse
//   o_err                   - with o_ack: misaligned or out-of-range access
//   o_rdata                 - with o_ack: read data (0 for writes/errors)
//   o_MemRead, o_MemWrite   - memory strobes
//   o_mem_addr, o_mem_wdata - memory address / write data
//   i_mem_rdata             - memory read data
// LATENCY (1..4) is the number of ACCESS cycles per valid transaction.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_we,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_addr2,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  input  logic [31:0] i_wdata2,
  output logic [2:0]  o_ack,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);
  localparam logic [1:0]  CNT_INIT       = 2'(LATENCY - 1);

  logic [1:0]  w_grant;
  logic        w_valid;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_bad;

  state_e      r_state;
  logic [1:0]  r_last;
  logic [1:0]  r_idx;
  logic        r_we;
  logic [1:0]  r_cnt;

  rr_pick3 u_pick (
    .i_req   (i_req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  // Fields of the candidate winner
  always_comb begin
    w_addr  = i_addr0;
    w_wdata = i_wdata0;
    w_we    = i_we[P_DATA];
    case (w_grant)
      P_FETCH: begin
        w_addr  = i_addr1;
        w_wdata = i_wdata1;
        w_we    = i_we[P_FETCH];
      end
      P_DEBUG: begin
        w_addr  = i_addr2;
        w_wdata = i_wdata2;
        w_we    = i_we[P_DEBUG];
      end
      default: ;
    endcase
    w_bad = (w_addr[1:0] != ALIGN_MASK) || (w_addr > LAST_WORD_ADDR);
  end

  // o_mem_addr / o_mem_wdata double as the latched address and write data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_last      <= P_DEBUG;
      r_idx       <= P_DATA;
      r_we        <= 1'b0;
      r_cnt       <= 2'd0;
      o_ack       <= 3'b000;
      o_err       <= 1'b0;
      o_rdata     <= '0;
      o_MemRead   <= 1'b0;
      o_MemWrite  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_valid) begin
            r_last <= w_grant;
            r_idx  <= w_grant;
            r_we   <= w_we;
            if (w_bad) begin
              // Rejected: straight to the response, memory never strobed
              r_state <= StResp;
              o_ack   <= port_onehot(w_grant);
              o_err   <= 1'b1;
              o_rdata <= '0;
            end else begin
              r_state     <= StAccess;
              r_cnt       <= CNT_INIT;
              o_mem_addr  <= w_addr;
              o_mem_wdata <= w_wdata;
              o_MemRead   <= ~w_we;
              // With a single ACCESS cycle the write strobe is due at once
              o_MemWrite  <= w_we && (CNT_INIT == 2'd0);
            end
          end
        end
        StAccess: begin
          if (r_cnt == 2'd0) begin
            r_state     <= StResp;
            o_ack       <= port_onehot(r_idx);
            o_err       <= 1'b0;
            o_rdata     <= r_we ? '0 : i_mem_rdata;
            o_MemRead   <= 1'b0;
            o_MemWrite  <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
          end else begin
            r_cnt      <= r_cnt - 2'd1;
            // Strobe only in the final ACCESS cycle
            o_MemWrite <= r_we && (r_cnt == 2'd1);
          end
        end
        StResp: begin
          r_state <= StIdle;
          o_ack   <= 3'b000;
          o_err   <= 1'b0;
          o_rdata <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
